// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm clock controller: mode encoding, field
// widths, wrap limits and the minute-tick helper used by counter and matcher.
package alarm_pkg;

    localparam int unsigned HH_W   = 5;
    localparam int unsigned MM_W   = 6;
    localparam int unsigned SNZ_W  = 6;
    localparam int unsigned RCNT_W = 8;
    localparam int unsigned MAX_HH = 23;
    localparam int unsigned MAX_MM = 59;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2,
        MODE_RING      = 2'd3
    } mode_e;

    typedef struct packed {
        logic [HH_W-1:0] hh;
        logic [MM_W-1:0] mm;
    } hhmm_t;

    // One-minute advance with hour carry and midnight wrap.
    function automatic hhmm_t hhmm_tick(input hhmm_t t);
        hhmm_t r;
        r = t;
        if (t.mm == MM_W'(MAX_MM)) begin
            r.mm = '0;
            r.hh = (t.hh == HH_W'(MAX_HH)) ? '0 : t.hh + HH_W'(1);
        end else begin
            r.mm = t.mm + MM_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/hhmm_counter.sv
// Hour:minute register with a carrying minute tick and carry-free manual
// hour/minute increments; tick wins over the edit inputs.
module hhmm_counter
    import alarm_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            tick_i,
    input  logic            inc_hh_i,
    input  logic            inc_mm_i,
    output logic [HH_W-1:0] hh_o,
    output logic [MM_W-1:0] mm_o
);

    hhmm_t cnt_q;
    hhmm_t cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (tick_i) begin
            cnt_d = hhmm_tick(cnt_q);
        end else if (inc_hh_i) begin
            cnt_d.hh = (cnt_q.hh == HH_W'(MAX_HH)) ? '0 : cnt_q.hh + HH_W'(1);
        end else if (inc_mm_i) begin
            cnt_d.mm = (cnt_q.mm == MM_W'(MAX_MM)) ? '0 : cnt_q.mm + MM_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hh_o = cnt_q.hh;
    assign mm_o = cnt_q.mm;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: mode FSM, time/alarm registers, alarm match,
// snooze countdown and unacknowledged-ring timeout.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned RING_SEC   = 60
) (
    input  logic            clk256,
    input  logic            reset,
    input  logic            one_second,
    input  logic            one_minute,
    input  logic            key_mode,
    input  logic            key_hour,
    input  logic            key_min,
    input  logic            key_alarm_en,
    input  logic            key_snooze,
    output logic [HH_W-1:0] time_hh,
    output logic [MM_W-1:0] time_mm,
    output logic [HH_W-1:0] alarm_hh,
    output logic [MM_W-1:0] alarm_mm,
    output logic            alarm_on,
    output logic            ring,
    output logic [1:0]      mode
);

    mode_e              mode_q;
    logic               ring_q;
    logic               alarm_on_q;
    logic               alarm_on_d;
    logic [SNZ_W-1:0]   snooze_q;
    logic [RCNT_W-1:0]  ring_cnt_q;
    logic [RCNT_W-1:0]  ring_cnt_inc;

    logic  alarm_en_w, mode_w, snooze_w, hour_w, min_w;
    logic  match_w;
    hhmm_t time_cur, time_nxt, alarm_cur;

    logic tick_time, t_inc_hh, t_inc_mm, a_inc_hh, a_inc_mm;

    // Only the highest-priority key pressed in a cycle takes effect.
    always_comb begin
        alarm_en_w   = key_alarm_en;
        mode_w       = key_mode & ~key_alarm_en;
        snooze_w     = key_snooze & ~key_mode & ~key_alarm_en;
        hour_w       = key_hour & ~key_snooze & ~key_mode & ~key_alarm_en;
        min_w        = key_min & ~key_hour & ~key_snooze & ~key_mode & ~key_alarm_en;
        alarm_on_d   = alarm_on_q ^ alarm_en_w;
        ring_cnt_inc = ring_cnt_q + RCNT_W'(1);
        time_cur.hh  = time_hh;
        time_cur.mm  = time_mm;
        alarm_cur.hh = alarm_hh;
        alarm_cur.mm = alarm_mm;
        time_nxt     = hhmm_tick(time_cur);
        match_w      = one_minute & (time_nxt == alarm_cur);
    end

    assign tick_time = one_minute & (mode_q != MODE_SET_TIME);
    assign t_inc_hh  = hour_w & (mode_q == MODE_SET_TIME);
    assign t_inc_mm  = min_w  & (mode_q == MODE_SET_TIME);
    assign a_inc_hh  = hour_w & (mode_q == MODE_SET_ALARM);
    assign a_inc_mm  = min_w  & (mode_q == MODE_SET_ALARM);

    hhmm_counter u_time (
        .clk_i    (clk256),
        .rst_i    (reset),
        .tick_i   (tick_time),
        .inc_hh_i (t_inc_hh),
        .inc_mm_i (t_inc_mm),
        .hh_o     (time_hh),
        .mm_o     (time_mm)
    );

    hhmm_counter u_alarm (
        .clk_i    (clk256),
        .rst_i    (reset),
        .tick_i   (1'b0),
        .inc_hh_i (a_inc_hh),
        .inc_mm_i (a_inc_mm),
        .hh_o     (alarm_hh),
        .mm_o     (alarm_mm)
    );

    always_ff @(posedge clk256 or posedge reset) begin
        if (reset) begin
            mode_q     <= MODE_RUN;
            ring_q     <= 1'b0;
            alarm_on_q <= 1'b0;
            snooze_q   <= '0;
            ring_cnt_q <= '0;
        end else begin
            alarm_on_q <= alarm_on_d;
            case (mode_q)
                MODE_RUN: begin
                    if (mode_w) begin
                        mode_q   <= MODE_SET_TIME;
                        snooze_q <= '0;
                    end else if (!alarm_on_d) begin
                        snooze_q <= '0;
                    end else if (snooze_q != '0) begin
                        // Pending snooze masks the time match until it expires.
                        if (one_minute) begin
                            snooze_q <= snooze_q - SNZ_W'(1);
                            if (snooze_q == SNZ_W'(1)) begin
                                mode_q     <= MODE_RING;
                                ring_q     <= 1'b1;
                                ring_cnt_q <= '0;
                            end
                        end
                    end else if (match_w) begin
                        mode_q     <= MODE_RING;
                        ring_q     <= 1'b1;
                        ring_cnt_q <= '0;
                    end
                end
                MODE_SET_TIME: begin
                    if (mode_w) begin
                        mode_q <= MODE_SET_ALARM;
                    end
                end
                MODE_SET_ALARM: begin
                    if (mode_w) begin
                        mode_q <= MODE_RUN;
                    end
                end
                MODE_RING: begin
                    if (alarm_en_w || mode_w) begin
                        mode_q   <= MODE_RUN;
                        ring_q   <= 1'b0;
                        snooze_q <= '0;
                    end else if (snooze_w) begin
                        mode_q   <= MODE_RUN;
                        ring_q   <= 1'b0;
                        snooze_q <= SNZ_W'(SNOOZE_MIN);
                    end else if (one_second) begin
                        ring_cnt_q <= ring_cnt_inc;
                        if (ring_cnt_inc == RCNT_W'(RING_SEC)) begin
                            mode_q   <= MODE_RUN;
                            ring_q   <= 1'b0;
                            snooze_q <= '0;
                        end
                    end
                end
                default: mode_q <= MODE_RUN;
            endcase
        end
    end

    assign mode     = mode_q;
    assign ring     = ring_q;
    assign alarm_on = alarm_on_q;

endmodule
